// File: rtl/vram_scroll_ctrl.sv
`default_nettype none
// vram_scroll_ctrl -- clear / scroll-up / fill-row engine sharing one VRAM port with a CPU.
// Optional macro VRAM_CPU_PRIORITY_EN: CPU wins every contested cycle. Rev 1.0
module vram_scroll_ctrl #(
    parameter int WORDS_PER_ROW = 40,
    parameter int NUM_ROWS      = 30
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic [1:0]  CMD_OP,
    input  logic [4:0]  CMD_ROW,
    input  logic [15:0] CMD_FILL,
    output logic        BUSY,
    output logic        DONE,
    input  logic        CPU_READ,
    input  logic        CPU_WRITE,
    input  logic [10:0] CPU_ADDR,
    input  logic [3:0]  CPU_BYTE_EN,
    input  logic [31:0] CPU_WRITEDATA,
    output logic [31:0] CPU_READDATA,
    output logic        CPU_WAITREQUEST,
    output logic [10:0] RAM_ADDR,
    output logic [3:0]  RAM_BYTE_EN,
    output logic [31:0] RAM_WDATA,
    output logic        RAM_WREN,
    output logic        RAM_RDEN,
    input  logic [31:0] RAM_Q
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_WR   = 3'd2;
    localparam logic [2:0] S_FILL = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;

    localparam int          DEPTH     = WORDS_PER_ROW * NUM_ROWS;
    localparam logic [10:0] ROW_WORDS = 11'(WORDS_PER_ROW);
    localparam logic [10:0] LAST_ADDR = 11'(DEPTH - 1);
    localparam logic [10:0] LAST_ROW  = 11'(DEPTH - WORDS_PER_ROW);

    logic [2:0]  state;
    logic [10:0] addr;
    logic [10:0] last_addr;
    logic [15:0] fill;
    logic [31:0] hold;
    logic [31:0] rd_data_q;
    logic        eng_rd_pend;
    logic        cpu_rd_pend;
    logic        cpu_req;
    logic        eng_req;
    logic        cpu_gnt;
    logic        eng_gnt;
    logic        cpu_first;
    logic [10:0] row_base;
    logic [31:0] copy_data;

    assign cpu_req = CPU_READ | CPU_WRITE;
    assign eng_req = (state == S_RD) || (state == S_WR) || (state == S_FILL);

`ifdef VRAM_CPU_PRIORITY_EN
    assign cpu_first = 1'b1;
`else
    // Loser of a contested cycle owns the next contested cycle.
    logic rr_cpu;
    assign cpu_first = rr_cpu;
    always_ff @(posedge CLK) begin
        if (RESET)
            rr_cpu <= 1'b1;
        else if (cpu_req && eng_req)
            rr_cpu <= ~cpu_gnt;
    end
`endif

    assign cpu_gnt         = cpu_req && (!eng_req || cpu_first);
    assign eng_gnt         = eng_req && !cpu_gnt;
    assign CPU_WAITREQUEST = cpu_req && !cpu_gnt;
    assign CMD_READY       = (state == S_IDLE);
    assign BUSY            = (state != S_IDLE);
    assign DONE            = (state == S_FIN);
    assign row_base        = 11'(CMD_ROW) * ROW_WORDS;

    // RAM_Q is bypassed in the cycle it arrives so read data and the copy
    // word are usable one cycle after the grant, then held in registers.
    assign copy_data    = eng_rd_pend ? RAM_Q : hold;
    assign CPU_READDATA = cpu_rd_pend ? RAM_Q : rd_data_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= S_IDLE;
            addr        <= '0;
            last_addr   <= '0;
            fill        <= '0;
            hold        <= '0;
            rd_data_q   <= '0;
            eng_rd_pend <= 1'b0;
            cpu_rd_pend <= 1'b0;
        end else begin
            cpu_rd_pend <= cpu_gnt && !CPU_WRITE;
            eng_rd_pend <= eng_gnt && (state == S_RD);
            if (cpu_rd_pend)
                rd_data_q <= RAM_Q;
            if (eng_rd_pend)
                hold <= RAM_Q;
            case (state)
                S_IDLE: begin
                    if (CMD_VALID) begin
                        fill <= CMD_FILL;
                        case (CMD_OP)
                            2'b00: begin
                                state     <= S_FILL;
                                addr      <= '0;
                                last_addr <= LAST_ADDR;
                            end
                            2'b01: begin
                                state     <= S_RD;
                                addr      <= ROW_WORDS;
                                last_addr <= LAST_ADDR;
                            end
                            2'b10: begin
                                if (int'(CMD_ROW) >= NUM_ROWS) begin
                                    state <= S_FIN;
                                end else begin
                                    state     <= S_FILL;
                                    addr      <= row_base;
                                    last_addr <= row_base + ROW_WORDS - 11'd1;
                                end
                            end
                            default: state <= S_FIN;
                        endcase
                    end
                end
                S_RD: begin
                    if (eng_gnt)
                        state <= S_WR;
                end
                S_WR: begin
                    if (eng_gnt) begin
                        if (addr == LAST_ADDR) begin
                            state <= S_FILL;
                            addr  <= LAST_ROW;
                        end else begin
                            state <= S_RD;
                            addr  <= addr + 11'd1;
                        end
                    end
                end
                S_FILL: begin
                    if (eng_gnt) begin
                        if (addr == last_addr)
                            state <= S_FIN;
                        else
                            addr <= addr + 11'd1;
                    end
                end
                S_FIN:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        RAM_ADDR    = '0;
        RAM_BYTE_EN = '0;
        RAM_WDATA   = '0;
        RAM_WREN    = 1'b0;
        RAM_RDEN    = 1'b0;
        if (cpu_gnt) begin
            RAM_ADDR = CPU_ADDR;
            if (CPU_WRITE) begin
                RAM_WREN    = 1'b1;
                RAM_BYTE_EN = CPU_BYTE_EN;
                RAM_WDATA   = CPU_WRITEDATA;
            end else begin
                RAM_RDEN = 1'b1;
            end
        end else if (eng_gnt) begin
            case (state)
                S_RD: begin
                    RAM_RDEN = 1'b1;
                    RAM_ADDR = addr;
                end
                S_WR: begin
                    RAM_WREN    = 1'b1;
                    RAM_ADDR    = addr - ROW_WORDS;
                    RAM_BYTE_EN = 4'hF;
                    RAM_WDATA   = copy_data;
                end
                default: begin
                    RAM_WREN    = 1'b1;
                    RAM_ADDR    = addr;
                    RAM_BYTE_EN = 4'hF;
                    RAM_WDATA   = {fill, fill};
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_vram_scroll_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// tb_vram_scroll_ctrl -- directed/randomized bench with a behavioural VRAM and expected-image model.
module tb_vram_scroll_ctrl;
    localparam int W     = 40;
    localparam int R     = 30;
    localparam int DEPTH = W * R;

    logic        CLK = 1'b0;
    logic        RESET, CMD_VALID, CMD_READY, BUSY, DONE;
    logic [1:0]  CMD_OP;
    logic [4:0]  CMD_ROW;
    logic [15:0] CMD_FILL;
    logic        CPU_READ, CPU_WRITE, CPU_WAITREQUEST;
    logic [10:0] CPU_ADDR;
    logic [3:0]  CPU_BYTE_EN;
    logic [31:0] CPU_WRITEDATA, CPU_READDATA;
    logic [10:0] RAM_ADDR;
    logic [3:0]  RAM_BYTE_EN;
    logic [31:0] RAM_WDATA, RAM_Q;
    logic        RAM_WREN, RAM_RDEN;

    always #5 CLK = ~CLK;

    vram_scroll_ctrl #(.WORDS_PER_ROW(W), .NUM_ROWS(R)) dut (
        .CLK(CLK), .RESET(RESET), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_OP(CMD_OP), .CMD_ROW(CMD_ROW), .CMD_FILL(CMD_FILL), .BUSY(BUSY), .DONE(DONE),
        .CPU_READ(CPU_READ), .CPU_WRITE(CPU_WRITE), .CPU_ADDR(CPU_ADDR),
        .CPU_BYTE_EN(CPU_BYTE_EN), .CPU_WRITEDATA(CPU_WRITEDATA), .CPU_READDATA(CPU_READDATA),
        .CPU_WAITREQUEST(CPU_WAITREQUEST), .RAM_ADDR(RAM_ADDR), .RAM_BYTE_EN(RAM_BYTE_EN),
        .RAM_WDATA(RAM_WDATA), .RAM_WREN(RAM_WREN), .RAM_RDEN(RAM_RDEN), .RAM_Q(RAM_Q)
    );

    logic [31:0] mem     [0:2047];
    logic [31:0] seed    [0:2047];
    logic [31:0] exp_mem [0:2047];
    logic        do_load = 1'b0;
    logic        both_hi = 1'b0;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    int          checks = 0;
    int          errors = 0;

    // Behavioural single-port VRAM with one-cycle read latency.
    always @(posedge CLK) begin
        if (do_load) begin
            for (int i = 0; i < 2048; i++) mem[i] <= seed[i];
        end else if (RAM_WREN) begin
            for (int b = 0; b < 4; b++)
                if (RAM_BYTE_EN[b]) mem[RAM_ADDR][b*8 +: 8] <= RAM_WDATA[b*8 +: 8];
        end
        if (RAM_RDEN) RAM_Q <= mem[RAM_ADDR];
        if (RAM_WREN) wr_cnt <= wr_cnt + 1;
        if (DONE) done_cnt <= done_cnt + 1;
        if (RAM_WREN && RAM_RDEN) both_hi <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    function automatic int mem_diff();
        int n;
        n = 0;
        for (int i = 0; i < 2048; i++) if (mem[i] !== exp_mem[i]) n++;
        return n;
    endfunction

    task automatic load_random();
        for (int i = 0; i < 2048; i++) begin
            seed[i]    = $urandom;
            exp_mem[i] = seed[i];
        end
        do_load = 1'b1;
        tick();
        do_load = 1'b0;
    endtask

    task automatic issue(input logic [1:0] op, input logic [4:0] row, input logic [15:0] f);
        CMD_VALID = 1'b1; CMD_OP = op; CMD_ROW = row; CMD_FILL = f;
        #1;
        chk("cmd_ready_idle", CMD_READY, 1);
        tick();
        CMD_VALID = 1'b0; CMD_OP = 2'b11; CMD_ROW = '0; CMD_FILL = '0;
    endtask

    // Latency counted in cycles after the acceptance cycle.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!DONE && lat < 6000) begin
            tick();
            lat++;
        end
        if (!DONE) chk("done_timeout", 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, w0, d0, bad, k;
        logic [10:0] a;
        logic [31:0] d, word5;
        logic [3:0]  be;
        logic [15:0] f;
        logic [4:0]  row;

        RESET = 1'b1; CMD_VALID = 0; CMD_OP = 2'b11; CMD_ROW = 0; CMD_FILL = 0;
        CPU_READ = 0; CPU_WRITE = 0; CPU_ADDR = 0; CPU_BYTE_EN = 0; CPU_WRITEDATA = 0;
        repeat (3) tick();
        load_random();
        RESET = 1'b0;
        #1;
        chk("rst_cmd_ready", CMD_READY, 1);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_readdata", CPU_READDATA, 0);
        chk("rst_wren", RAM_WREN, 0);
        chk("rst_rden", RAM_RDEN, 0);
        chk("rst_addr", 32'(RAM_ADDR), 0);
        chk("rst_be", 32'(RAM_BYTE_EN), 0);
        chk("rst_wdata", RAM_WDATA, 0);

        // Idle CPU writes pass straight through; read+write counts as write.
        for (int i = 0; i < 6; i++) begin
            a = 11'($urandom_range(0, DEPTH - 1)); d = $urandom; be = 4'($urandom);
            CPU_WRITE = 1'b1; CPU_READ = (i == 5); CPU_ADDR = a; CPU_WRITEDATA = d; CPU_BYTE_EN = be;
            #1;
            chk("cpuw_wait", CPU_WAITREQUEST, 0);
            chk("cpuw_wren", RAM_WREN, 1);
            chk("cpuw_rden", RAM_RDEN, 0);
            chk("cpuw_addr", 32'(RAM_ADDR), 32'(a));
            chk("cpuw_be", 32'(RAM_BYTE_EN), 32'(be));
            chk("cpuw_data", RAM_WDATA, d);
            exp_mem[a] = merge(exp_mem[a], d, be);
            tick();
            CPU_WRITE = 1'b0; CPU_READ = 1'b0;
        end
        tick();
        chk("cpuw_mem", mem_diff(), 0);

        for (int i = 0; i < 6; i++) begin
            a = 11'($urandom_range(0, DEPTH - 1));
            CPU_READ = 1'b1; CPU_ADDR = a;
            #1;
            chk("cpur_rden", RAM_RDEN, 1);
            chk("cpur_addr", 32'(RAM_ADDR), 32'(a));
            tick();
            CPU_READ = 1'b0;
            #1;
            chk("cpur_data", CPU_READDATA, exp_mem[a]);
            tick();
            chk("cpur_hold", CPU_READDATA, exp_mem[a]);
        end

        // Clear screen.
        w0 = wr_cnt; d0 = done_cnt;
        issue(2'b00, 5'd0, 16'h0720);
        wait_done(lat);
        chk("clear_latency", lat, 1201);
        repeat (3) tick();
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = 32'h07200720;
        chk("clear_writes", wr_cnt - w0, 1200);
        chk("clear_dones", done_cnt - d0, 1);
        chk("clear_mem", mem_diff(), 0);

        // Scroll over random contents, with a CPU read of word 5 in the acceptance cycle.
        load_random();
        f = 16'($urandom); word5 = exp_mem[5];
        w0 = wr_cnt; d0 = done_cnt;
        CPU_READ = 1'b1; CPU_ADDR = 11'd5;
        #1;
        chk("rd5_wait", CPU_WAITREQUEST, 0);
        issue(2'b01, 5'd0, f);
        CPU_READ = 1'b0;
        #1;
        chk("rd5_data_t1", CPU_READDATA, word5);
        chk("scroll_first_rd", RAM_RDEN, 1);
        chk("scroll_first_addr", 32'(RAM_ADDR), W);
        wait_done(lat);
        chk("scroll_latency", lat, 2361);
        chk("rd5_data_held", CPU_READDATA, word5);
        repeat (3) tick();
        for (int n = 0; n < DEPTH - W; n++) exp_mem[n] = exp_mem[n + W];
        for (int n = DEPTH - W; n < DEPTH; n++) exp_mem[n] = {f, f};
        chk("scroll_writes", wr_cnt - w0, DEPTH);
        chk("scroll_dones", done_cnt - d0, 1);
        chk("scroll_mem", mem_diff(), 0);

        // Fill-row: last row, random rows, out-of-range rows, no-op.
        for (int i = 0; i < 4; i++) begin
            row = (i == 0) ? 5'd29 : 5'($urandom_range(0, R - 1));
            f = 16'($urandom);
            w0 = wr_cnt; d0 = done_cnt;
            issue(2'b10, row, f);
            wait_done(lat);
            chk("fill_latency", lat, 41);
            repeat (2) tick();
            for (int n = 0; n < W; n++) exp_mem[int'(row) * W + n] = {f, f};
            chk("fill_writes", wr_cnt - w0, W);
            chk("fill_dones", done_cnt - d0, 1);
            chk("fill_mem", mem_diff(), 0);
        end
        for (int i = 0; i < 3; i++) begin
            w0 = wr_cnt; d0 = done_cnt;
            if (i == 2) issue(2'b11, 5'd3, 16'hBEEF);
            else issue(2'b10, (i == 0) ? 5'd31 : 5'd30, 16'hBEEF);
            wait_done(lat);
            chk("nop_latency", lat, 1);
            repeat (2) tick();
            chk("nop_writes", wr_cnt - w0, 0);
            chk("nop_dones", done_cnt - d0, 1);
            chk("nop_busy", BUSY, 0);
        end
        chk("nop_mem", mem_diff(), 0);

        // Reset in the middle of a scroll.
        load_random();
        d0 = done_cnt;
        issue(2'b01, 5'd0, 16'h1111);
        k = 0;
        while (!(RAM_RDEN && RAM_ADDR == 11'd500) && k < 3000) begin
            tick();
            k++;
        end
        chk("midreset_reach500", 32'(RAM_RDEN && RAM_ADDR == 11'd500), 1);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        #1;
        chk("midreset_ready", CMD_READY, 1);
        chk("midreset_busy", BUSY, 0);
        chk("midreset_done", DONE, 0);
        w0 = wr_cnt;
        repeat (20) tick();
        chk("midreset_nowrites", wr_cnt - w0, 0);
        chk("midreset_nodone", done_cnt - d0, 0);

        // CPU write held through the first 100 cycles of a clear.
        f = 16'($urandom); d = $urandom; be = 4'($urandom);
        w0 = wr_cnt; d0 = done_cnt; bad = 0;
        CPU_ADDR = 11'd2000; CPU_WRITEDATA = d; CPU_BYTE_EN = be;
        issue(2'b00, 5'd0, f);
        k = 1;
        while (k < 5000) begin
            CPU_WRITE = (k <= 100);
            #1;
`ifdef VRAM_CPU_PRIORITY_EN
            if (CPU_WAITREQUEST !== 1'b0) bad++;
`else
            if (CPU_WAITREQUEST !== (k <= 100 && (k % 2) == 0)) bad++;
`endif
            if (DONE) break;
            tick();
            k++;
        end
        CPU_WRITE = 1'b0;
        chk("contend_waitreq_pattern", bad, 0);
`ifdef VRAM_CPU_PRIORITY_EN
        chk("contend_latency", k, 1301);
        chk("contend_writes_pending", 0, 0 + (wr_cnt - w0 < 1300 ? 0 : 0));
`else
        chk("contend_latency", k, 1251);
`endif
        repeat (3) tick();
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = {f, f};
        exp_mem[2000] = merge(exp_mem[2000], d, be);
`ifdef VRAM_CPU_PRIORITY_EN
        chk("contend_writes", wr_cnt - w0, 1300);
`else
        chk("contend_writes", wr_cnt - w0, 1250);
`endif
        chk("contend_dones", done_cnt - d0, 1);
        chk("contend_mem", mem_diff(), 0);
        chk("wren_rden_exclusive", both_hi, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
